// File: rtl/snitch_icache_data_banked_if.sv
// Read/refill port bundle of the banked icache data array.
// The rd_rsp_err field exists only when SNITCH_ICACHE_DATA_PARITY_EN is defined.
interface snitch_icache_data_banked_if #(
  parameter int unsigned WAY_COUNT  = 4,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned LINE_COUNT = 64
);
  localparam int unsigned ADDR_W = $clog2(LINE_COUNT);
  localparam int unsigned WAY_W  = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;

  logic                            rd_req_valid;
  logic                            rd_req_ready;
  logic [ADDR_W-1:0]               rd_addr;
  logic [WAY_COUNT-1:0]            rd_way_en;
  logic                            rd_rsp_valid;
  logic                            rd_rsp_ready;
  logic [WAY_COUNT*LINE_WIDTH-1:0] rd_rsp_data;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
  logic [WAY_COUNT-1:0]            rd_rsp_err;
`endif
  logic                            wr_valid;
  logic                            wr_ready;
  logic [ADDR_W-1:0]               wr_addr;
  logic [WAY_W-1:0]                wr_way;
  logic [LINE_WIDTH-1:0]           wr_data;

  // lookup stage and refill handler
  modport master (
    output rd_req_valid, rd_addr, rd_way_en, rd_rsp_ready,
    output wr_valid, wr_addr, wr_way, wr_data,
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
    input  rd_rsp_err,
`endif
    input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
  );

  // data array
  modport slave (
    input  rd_req_valid, rd_addr, rd_way_en, rd_rsp_ready,
    input  wr_valid, wr_addr, wr_way, wr_data,
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
    output rd_rsp_err,
`endif
    output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
  );
endinterface

// File: rtl/snitch_icache_data_banked.sv
// Banked icache data array: decoupled read port, one-entry refill buffer with
// forwarding, starvation-bounded bank arbitration. Optional: SNITCH_ICACHE_DATA_PARITY_EN.

// Single-port, latency-1 SRAM macro model.
module tc_sram_impl #(
  parameter int unsigned NumWords  = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter type         impl_in_t = logic,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  impl_in_t             impl_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic [DataWidth-1:0] rdata_o
);
  logic [DataWidth-1:0] mem [NumWords];
  logic                 unused_impl;

  assign unused_impl = ^impl_i;

  always_ff @(posedge clk_i) begin
    if (req_i && we_i) begin
      for (int i = 0; i < int'(DataWidth); i++) begin
        if (be_i[i/ByteWidth]) mem[addr_i][i] <= wdata_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)              rdata_o <= '0;
    else if (req_i && !we_i)  rdata_o <= mem[addr_i];
  end
endmodule

// Write buffer FSM
//   state     | meaning
//   BUF_EMPTY | no refill held, wr_ready high
//   BUF_HELD  | refill captured, waiting for a free bank slot
module snitch_icache_data_banked #(
  parameter int unsigned WAY_COUNT    = 4,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned LINE_COUNT   = 64,
  parameter int unsigned BANK_COUNT   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter type         sram_cfg_data_t = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  sram_cfg_data_t            sram_cfg_data_i,
  snitch_icache_data_banked_if.slave bus
);
  localparam int unsigned ADDR_W    = $clog2(LINE_COUNT);
  localparam int unsigned WAY_W     = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
  localparam int unsigned BANK_BITS = $clog2(BANK_COUNT);
  localparam int unsigned BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_COUNT = LINE_COUNT / BANK_COUNT;
  localparam int unsigned ROW_W     = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam int unsigned CNT_W     = $clog2(STARVE_LIMIT + 1);
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
  localparam int unsigned SRAM_W    = LINE_WIDTH + 1;
`else
  localparam int unsigned SRAM_W    = LINE_WIDTH;
`endif

  typedef enum logic {BUF_EMPTY, BUF_HELD} buf_state_e;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = a & ADDR_W'(BANK_COUNT - 1);
    return BANK_W'(m);
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return ROW_W'(a >> BANK_BITS);
  endfunction

  buf_state_e                    buf_state_q, buf_state_d;
  logic                          buf_valid;
  logic [ADDR_W-1:0]             buf_addr;
  logic [WAY_W-1:0]              buf_way;
  logic [LINE_WIDTH-1:0]         buf_data;
  logic [CNT_W-1:0]              starve_cnt;

  logic [BANK_W-1:0]             rd_bank, buf_bank;
  logic                          same_bank, starved, rd_ready, rd_fire;
  logic                          conflict, wr_commit, wr_accept, fwd_hit;
  logic [WAY_COUNT-1:0]          fwd_mask;

  logic                          rsp_valid, rsp_fresh;
  logic [BANK_W-1:0]             rsp_bank;
  logic [WAY_COUNT-1:0]          rsp_way_en, rsp_fwd;
  logic [LINE_WIDTH-1:0]         fwd_data;
  logic [WAY_COUNT*LINE_WIDTH-1:0] rsp_data_now, hold_data;
  logic [SRAM_W-1:0]             rsp_word;
  logic [SRAM_W-1:0]             sram_wdata;
  logic [WAY_COUNT*BANK_COUNT*SRAM_W-1:0] sram_rdata;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
  logic [WAY_COUNT-1:0]          rsp_err_now, hold_err;
`endif

  assign buf_valid = (buf_state_q == BUF_HELD);
  assign rd_bank   = bank_of(bus.rd_addr);
  assign buf_bank  = bank_of(buf_addr);
  assign same_bank = (rd_bank == buf_bank);
  assign starved   = buf_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
  // A starved write only blocks reads to its own bank.
  assign rd_ready  = !(rsp_valid && !bus.rd_rsp_ready) && !(starved && same_bank);
  assign rd_fire   = bus.rd_req_valid && rd_ready;
  assign conflict  = buf_valid && rd_fire && same_bank;
  assign wr_commit = buf_valid && !conflict;
  assign wr_accept = bus.wr_valid && !buf_valid;
  assign fwd_hit   = buf_valid && (bus.rd_addr == buf_addr) && bus.rd_way_en[buf_way];
  assign fwd_mask  = fwd_hit ? (WAY_COUNT'(1) << buf_way) : '0;

  assign bus.wr_ready     = !buf_valid;
  assign bus.rd_req_ready = rd_ready;
  assign bus.rd_rsp_valid = rsp_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) buf_state_q <= BUF_EMPTY;
    else       buf_state_q <= buf_state_d;
  end

  always_comb begin
    buf_state_d = buf_state_q;
    case (buf_state_q)
      BUF_EMPTY: if (bus.wr_valid) buf_state_d = BUF_HELD;
      BUF_HELD:  if (wr_commit)    buf_state_d = BUF_EMPTY;
      default:                     buf_state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_addr   <= '0;
      buf_way    <= '0;
      buf_data   <= '0;
      starve_cnt <= '0;
    end else begin
      if (wr_accept) begin
        buf_addr <= bus.wr_addr;
        buf_way  <= bus.wr_way;
        buf_data <= bus.wr_data;
      end
      if (wr_commit) begin
        starve_cnt <= '0;
      end else if (conflict && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SNITCH_ICACHE_DATA_PARITY_EN
  assign sram_wdata = {^buf_data, buf_data};
`else
  assign sram_wdata = buf_data;
`endif

  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
      logic sel_wr, sel_rd;
      // Commit and read never target the same macro in one cycle.
      assign sel_wr = wr_commit && (buf_bank == BANK_W'(b)) && (buf_way == WAY_W'(w));
      assign sel_rd = rd_fire && (rd_bank == BANK_W'(b)) && bus.rd_way_en[w];

      tc_sram_impl #(
        .NumWords  (ROW_COUNT),
        .DataWidth (SRAM_W),
        .ByteWidth (SRAM_W),
        .impl_in_t (sram_cfg_data_t)
      ) i_sram (
        .clk_i   (clk_i),
        .rst_ni  (!rst_i),
        .impl_i  (sram_cfg_data_i),
        .req_i   (sel_wr || sel_rd),
        .we_i    (sel_wr),
        .addr_i  (sel_wr ? row_of(buf_addr) : row_of(bus.rd_addr)),
        .wdata_i (sram_wdata),
        .be_i    ('1),
        .rdata_o (sram_rdata[(w*BANK_COUNT+b)*SRAM_W +: SRAM_W])
      );
    end
  end

  always_comb begin
    rsp_data_now = '0;
    rsp_word     = '0;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
    rsp_err_now  = '0;
`endif
    for (int w = 0; w < int'(WAY_COUNT); w++) begin
      rsp_word = sram_rdata[(w*int'(BANK_COUNT) + int'(rsp_bank))*int'(SRAM_W) +: SRAM_W];
      if (rsp_way_en[w]) begin
        if (rsp_fwd[w]) begin
          rsp_data_now[w*LINE_WIDTH +: LINE_WIDTH] = fwd_data;
        end else begin
          rsp_data_now[w*LINE_WIDTH +: LINE_WIDTH] = rsp_word[LINE_WIDTH-1:0];
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
          rsp_err_now[w] = rsp_word[LINE_WIDTH] != ^rsp_word[LINE_WIDTH-1:0];
`endif
        end
      end
    end
  end

  // SRAM output is live only in the cycle after the read; afterwards the hold copy drives.
  assign bus.rd_rsp_data = rsp_fresh ? rsp_data_now : hold_data;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
  assign bus.rd_rsp_err  = rsp_fresh ? rsp_err_now : hold_err;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid  <= 1'b0;
      rsp_fresh  <= 1'b0;
      rsp_bank   <= '0;
      rsp_way_en <= '0;
      rsp_fwd    <= '0;
      fwd_data   <= '0;
      hold_data  <= '0;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
      hold_err   <= '0;
`endif
    end else begin
      rsp_fresh <= rd_fire;
      if (rd_fire) begin
        rsp_valid  <= 1'b1;
        rsp_bank   <= rd_bank;
        rsp_way_en <= bus.rd_way_en;
        rsp_fwd    <= fwd_mask;
        fwd_data   <= buf_data;
      end else if (bus.rd_rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
      if (rsp_fresh) begin
        hold_data <= rsp_data_now;
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
        hold_err  <= rsp_err_now;
`endif
      end
    end
  end
endmodule

// File: tb/tb_snitch_icache_data_banked.sv
// Randomized bench for snitch_icache_data_banked against a line-level reference model.
module tb_snitch_icache_data_banked;
  localparam int WAYS  = 4;
  localparam int LW    = 128;
  localparam int LINES = 64;
  localparam int BANKS = 2;
  localparam int LIMIT = 4;
  localparam int DW    = WAYS * LW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg = 1'b0;

  always #5 clk = ~clk;

  snitch_icache_data_banked_if #(.WAY_COUNT(WAYS), .LINE_WIDTH(LW), .LINE_COUNT(LINES)) bus ();

  snitch_icache_data_banked #(
    .WAY_COUNT(WAYS), .LINE_WIDTH(LW), .LINE_COUNT(LINES),
    .BANK_COUNT(BANKS), .STARVE_LIMIT(LIMIT), .sram_cfg_data_t(logic)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sram_cfg_data_i(cfg), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model: whole lines per way, plus the pending refill and response slot
  logic [LW-1:0]   m_mem [WAYS][LINES];
  bit              m_bad [WAYS][LINES];
  bit              m_buf_v;
  logic [5:0]      m_buf_addr;
  logic [1:0]      m_buf_way;
  logic [LW-1:0]   m_buf_data;
  int              m_lost;
  bit              m_rsp_v;
  logic [DW-1:0]   m_rsp_data;
  logic [WAYS-1:0] m_rsp_err;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit rv, input logic [5:0] ra, input logic [3:0] re, input bit rr,
                       input bit wv, input logic [5:0] wa, input logic [1:0] ww, input logic [LW-1:0] wd);
    bus.rd_req_valid = rv;
    bus.rd_addr      = ra;
    bus.rd_way_en    = re;
    bus.rd_rsp_ready = rr;
    bus.wr_valid     = wv;
    bus.wr_addr      = wa;
    bus.wr_way       = ww;
    bus.wr_data      = wd;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b0, 6'd0, 2'd0, '0);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit exp_rdy, starved, fire, confl, commit, wr_acc, rr;
    logic [5:0] ra, wa;
    logic [1:0] ww;
    logic [LW-1:0] wd;
    logic [DW-1:0] rdata;
    logic [WAYS-1:0] rerr;
    @(negedge clk);
    ra      = bus.rd_addr;
    rr      = bus.rd_rsp_ready;
    starved = m_buf_v && (m_lost == LIMIT);
    exp_rdy = !(m_rsp_v && !rr) && !(starved && (ra % BANKS) == (m_buf_addr % BANKS));
    check("wr_ready", bus.wr_ready, !m_buf_v);
    check("rd_req_ready", bus.rd_req_ready, exp_rdy);
    check("rsp_valid", bus.rd_rsp_valid, m_rsp_v);
    if (m_rsp_v) begin
      check("rsp_data", bus.rd_rsp_data, m_rsp_data);
`ifdef SNITCH_ICACHE_DATA_PARITY_EN
      check("rsp_err", bus.rd_rsp_err, m_rsp_err);
`endif
    end
    fire   = bus.rd_req_valid && exp_rdy;
    confl  = m_buf_v && fire && ((ra % BANKS) == (m_buf_addr % BANKS));
    commit = m_buf_v && !confl;
    wr_acc = bus.wr_valid && !m_buf_v;
    wa = bus.wr_addr; ww = bus.wr_way; wd = bus.wr_data;
    rdata = '0;
    rerr  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.rd_way_en[w]) begin
        if (m_buf_v && ra == m_buf_addr && int'(m_buf_way) == w) begin
          rdata[w*LW +: LW] = m_buf_data;
        end else begin
          rdata[w*LW +: LW] = m_mem[w][ra];
          rerr[w] = m_bad[w][ra];
        end
      end
    end
    @(posedge clk);
    #1;
    if (commit) begin
      m_mem[m_buf_way][m_buf_addr] = m_buf_data;
      m_bad[m_buf_way][m_buf_addr] = 1'b0;
      m_buf_v = 1'b0;
      m_lost  = 0;
    end else if (confl && m_lost < LIMIT) begin
      m_lost++;
    end
    if (wr_acc) begin
      m_buf_v = 1'b1; m_buf_addr = wa; m_buf_way = ww; m_buf_data = wd;
    end
    if (fire) begin
      m_rsp_v = 1'b1; m_rsp_data = rdata; m_rsp_err = rerr;
    end else if (rr) begin
      m_rsp_v = 1'b0;
    end
  endtask

  task automatic wait_wr_ready(input string tag);
    int n;
    n = 0;
    idle();
    while (!bus.wr_ready && n < 16) begin
      cycle();
      n++;
    end
    check(tag, bus.wr_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] d;
    logic [5:0] a, wa;
    bit rv, rr, wv;
    m_buf_v = 0; m_buf_addr = 0; m_buf_way = 0; m_buf_data = 0; m_lost = 0;
    m_rsp_v = 0; m_rsp_data = 0; m_rsp_err = 0;
    for (int w = 0; w < WAYS; w++)
      for (int l = 0; l < LINES; l++) begin m_mem[w][l] = '0; m_bad[w][l] = 1'b0; end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_ready", bus.wr_ready, 1'b1);
    check("rst_rsp_valid", bus.rd_rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rd_rsp_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // preload every line so reads have defined contents
    for (int l = 0; l < LINES; l++)
      for (int w = 0; w < WAYS; w++) begin
        drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1, 6'(l), 2'(w), rand_line());
        cycle();
        idle();
        cycle();
      end

`ifdef SNITCH_ICACHE_DATA_PARITY_EN
    dut.g_way[3].g_bank[1].i_sram.mem[3][0] <= ~dut.g_way[3].g_bank[1].i_sram.mem[3][0];
    #1;
    m_mem[3][7][0] = ~m_mem[3][7][0];
    m_bad[3][7] = 1'b1;
    drive(1'b1, 6'd7, 4'b1111, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    check("par_err", bus.rd_rsp_err, 4'b1000);
    idle();
    cycle();
`endif

    // refill then read back a single way
    d = {16{8'hA5}};
    drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1, 6'd5, 2'd2, d);
    cycle();
    wait_wr_ready("t1_wr_ready");
    drive(1'b1, 6'd5, 4'b0100, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    check("t1_rsp_valid", bus.rd_rsp_valid, 1'b1);
    check("t1_rsp_data", bus.rd_rsp_data, {128'h0, d, 128'h0, 128'h0});
    idle();
    cycle();

    // response backpressure
    drive(1'b1, 6'd10, 4'b1111, 1'b0, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 6'd11, 4'b1111, 1'b0, 1'b0, 6'd0, 2'd0, '0);
      #1;
      check("t2_blocked", bus.rd_req_ready, 1'b0);
      check("t2_held", bus.rd_rsp_valid, 1'b1);
      cycle();
    end
    drive(1'b1, 6'd11, 4'b1111, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    #1;
    check("t2_next_accept", bus.rd_req_ready, 1'b1);
    cycle();
    idle();
    cycle();

    // starvation: bank-1 reads stream, 5th cycle blocks bank 1 or admits bank 0
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1, 6'd9, 2'd1, rand_line());
      cycle();
      for (int k = 1; k <= 5; k++) begin
        a = 6'($urandom_range(0, 31) * 2 + 1);
        if (k == 5 && s == 1) a = 6'($urandom_range(0, 31) * 2);
        drive(1'b1, a, 4'($urandom), 1'b1, 1'b0, 6'd0, 2'd0, '0);
        #1;
        check("t3_wr_pending", bus.wr_ready, 1'b0);
        check("t3_rd_ready", bus.rd_req_ready, !(k == 5 && s == 0));
        cycle();
      end
      check("t3_committed", bus.wr_ready, 1'b1);
      idle();
      cycle();
    end

    // forwarding from a conflict-blocked buffer
    d = rand_line();
    drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1, 6'd3, 2'd0, d);
    cycle();
    drive(1'b1, 6'd3, 4'b0001, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    check("t4_fwd_data", bus.rd_rsp_data, {384'h0, d});
    wait_wr_ready("t4_wr_ready");
    drive(1'b1, 6'd3, 4'b0001, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    idle();
    cycle();

    // reset with buffer full and response pending
    drive(1'b0, 6'd0, 4'd0, 1'b1, 1'b1, 6'd4, 2'd1, rand_line());
    cycle();
    drive(1'b1, 6'd6, 4'b1111, 1'b0, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    check("t5_pre_wr_ready", bus.wr_ready, 1'b0);
    check("t5_pre_rsp_valid", bus.rd_rsp_valid, 1'b1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("t5_wr_ready", bus.wr_ready, 1'b1);
    check("t5_rsp_valid", bus.rd_rsp_valid, 1'b0);
    m_buf_v = 1'b0; m_rsp_v = 1'b0; m_lost = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 6'd4, 4'b1111, 1'b1, 1'b0, 6'd0, 2'd0, '0);
    cycle();
    idle();
    cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      a  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      wa = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 9) < 3);
      drive(rv, a, 4'($urandom), rr, wv, wa, 2'($urandom), rand_line());
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snitch_icache_data_banked.md
Name: snitch_icache_data_banked

Overview:
Banked, set-interleaved instruction-cache data array. It succeeds the single-port per-way array and adds a decoupled read port with response backpressure, a one-entry refill write buffer, and bank-conflict arbitration with starvation protection. Refill data held in the buffer is forwarded to reads. It sits between the icache lookup stage (read) and the refill handler (write).

Parameters:
WAY_COUNT, 4, number of ways; every read returns all enabled ways in parallel.
LINE_WIDTH, 128, bits per cache line.
LINE_COUNT, 64, lines per way; must be a multiple of BANK_COUNT.
BANK_COUNT, 2, power of two, ≥1; bank = addr[log2(BANK_COUNT)-1:0], row = addr >> log2(BANK_COUNT).
STARVE_LIMIT, 4, cycles a buffered write may lose arbitration before it takes priority; ≥1.
sram_cfg_data_t, logic, SRAM implementation config type, passed to every macro.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
sram_cfg_data_i  in  sram_cfg_data_t  SRAM config, fanned out to all macros
rd_req_valid_i  in  1  read request valid
rd_req_ready_o  out  1  read request accepted when valid&ready
rd_addr_i  in  $clog2(LINE_COUNT)  line index
rd_way_en_i  in  WAY_COUNT  ways to read; disabled ways return 0
rd_rsp_valid_o  out  1  response valid
rd_rsp_ready_i  in  1  response consumed when valid&ready
rd_rsp_data_o  out  WAY_COUNT*LINE_WIDTH  per-way line data
wr_valid_i  in  1  refill write valid
wr_ready_o  out  1  write buffer empty
wr_addr_i  in  $clog2(LINE_COUNT)  line index
wr_way_i  in  $clog2(WAY_COUNT) (min 1)  binary target way
wr_data_i  in  LINE_WIDTH  refill line
rd_rsp_err_o  out  WAY_COUNT  parity error per way (only with the optional feature)

Behaviour:
- Storage: WAY_COUNT×BANK_COUNT tc_sram_impl instances, each LINE_COUNT/BANK_COUNT words, 1 port, latency 1, be all ones.
- Reset (asynchronous, active-high) values: rd_rsp_valid_o=0, rd_rsp_data_o=0, wr_ready_o=1, write buffer empty, starvation counter=0. Reset mid-transfer drops any buffered write and any pending response. SRAM contents are not cleared.
- Write buffer: accepts on wr_valid_i&wr_ready_o and captures addr/way/data. wr_ready_o=!buf_valid (registered). The earliest SRAM commit is the cycle after acceptance. Once committed, the buffer is empty the next cycle.
- Arbitration, per cycle:
  - Write commits when its bank is not targeted by an accepted read.
  - When it conflicts, the read wins and the starvation counter increments.
  - When counter==STARVE_LIMIT, the write wins and rd_req_ready_o is forced 0 for reads to that bank. Reads to other banks proceed in the same cycle.
  - The counter clears on commit. It saturates and never wraps.
- Read: rd_req_ready_o = !(rd_rsp_valid_o & !rd_rsp_ready_i) & !(starved write to same bank). One response slot; it accepts back-to-back reads at full throughput when rd_rsp_ready_i=1.
  - Request accepted in cycle t → rd_rsp_valid_o=1 in cycle t+1.
  - SRAM data is captured into a hold register, so data stays stable while valid&!ready.
  - rd_rsp_valid_o drops the cycle after the handshake unless a new read was accepted.
- Forwarding: if a read is accepted while buf_valid, addr==buf_addr and rd_way_en_i[buf_way]=1, that way's response equals buf_data. This holds even if the buffer commits in the same cycle.
- A write commit and a read of the same line in the same cycle cannot occur (same bank), so no SRAM read-during-write case exists.
- BANK_COUNT=1: every pending write conflicts with any read; the starvation rule guarantees progress.

Optional Feature:
SNITCH_ICACHE_DATA_PARITY_EN
- Defined: each macro stores LINE_WIDTH+1 bits; the extra bit is the even parity of the line, computed on write. rd_rsp_err_o[w] = stored parity ≠ recomputed parity for enabled way w, held with the response data. Forwarded data never flags an error.
- Undefined: port rd_rsp_err_o is absent, macros are LINE_WIDTH wide, and there is no parity logic.

Test Plan:
- Write way2 addr 5 data 0xA5..A5, wait for wr_ready_o=1, read addr 5 ways 4'b0100 → response next cycle, way2=0xA5..A5, other ways 0.
- Read accepted with rd_rsp_ready_i=0 for 3 cycles → rd_rsp_valid_o held 1 and data stable, rd_req_ready_o=0; ready=1 → handshake, next read accepted the same cycle.
- Write addr 9 way1 while reads to bank 1 stream every cycle (BANK_COUNT=2, STARVE_LIMIT=4) → write commits exactly on the 5th cycle after acceptance with rd_req_ready_o=0 that cycle; a bank-0 read in the same cycle is still accepted.
- Buffered write addr 3 way0 blocked by conflict, read addr 3 way0 → response returns the buffered data, not stale SRAM content.
- Assert rst_i while the buffer is full and a response is pending → wr_ready_o=1 and rd_rsp_valid_o=0 immediately; after release, reads operate normally.
- With the macro defined, force-flip one stored bit via backdoor on way3 addr 7, then read → rd_rsp_err_o=4'b1000.
